// File: rtl/hand_bbox_tracker_pkg.sv
// Shared constants for the hand bounding-box tracker: coordinate width,
// default raster size, tracker state encodings and accumulator init values.
package hand_bbox_tracker_pkg;
  localparam int COORD_W      = 11;
  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_FINAL = 2'd2;

  localparam logic [COORD_W-1:0] MIN_INIT = {COORD_W{1'b1}};
  localparam logic [COORD_W-1:0] MAX_INIT = '0;

  typedef struct packed {
    logic [COORD_W-1:0] x_min;
    logic [COORD_W-1:0] x_max;
    logic [COORD_W-1:0] y_min;
    logic [COORD_W-1:0] y_max;
  } bbox_t;

  localparam bbox_t BBOX_INIT = '{x_min: MIN_INIT, x_max: MAX_INIT,
                                  y_min: MIN_INIT, y_max: MAX_INIT};
endpackage

// File: rtl/hand_bbox_tracker_if.sv
// Bounding-box bus between the tracker (master) and the overlay stage (slave).
interface hand_bbox_tracker_if;
  import hand_bbox_tracker_pkg::*;
  logic [COORD_W-1:0] hand_x_min;
  logic [COORD_W-1:0] hand_x_max;
  logic [COORD_W-1:0] hand_y_min;
  logic [COORD_W-1:0] hand_y_max;
  logic               bbox_found;
  logic               bbox_valid;
  logic               frame_dropped;

  modport master (output hand_x_min, hand_x_max, hand_y_min, hand_y_max,
                  output bbox_found, bbox_valid, frame_dropped);
  modport slave  (input  hand_x_min, hand_x_max, hand_y_min, hand_y_max,
                  input  bbox_found, bbox_valid, frame_dropped);
endinterface

// File: rtl/hand_bbox_tracker_raster_counter.sv
// Raster position of the pixel presented this cycle; sof forces (0,0) so a
// resync needs no extra cycle. The registers hold the coordinate of the next pixel.
module hand_bbox_tracker_raster_counter
  import hand_bbox_tracker_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               step,
  input  logic               sof,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               last
);
  logic [COORD_W-1:0] nx, ny;

  assign x    = sof ? '0 : nx;
  assign y    = sof ? '0 : ny;
  assign last = (x == COORD_W'(H_ACTIVE-1)) && (y == COORD_W'(V_ACTIVE-1));

  always_ff @(posedge clk) begin
    if (reset) begin
      nx <= '0;
      ny <= '0;
    end else if (step) begin
      if (x == COORD_W'(H_ACTIVE-1)) begin
        nx <= '0;
        ny <= last ? '0 : y + COORD_W'(1);
      end else begin
        nx <= x + COORD_W'(1);
        ny <= y;
      end
    end
  end
endmodule

// File: rtl/hand_bbox_tracker.sv
// Thresholds the pixel stream, accumulates the min/max extent of hit pixels per
// frame and commits the box one cycle after the last pixel of the frame.
module hand_bbox_tracker
  import hand_bbox_tracker_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int MIN_PIXELS = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            pixel_in,
  input  logic                  pixel_valid,
  input  logic                  sof,
  input  logic [7:0]            threshold,
  hand_bbox_tracker_if.master   bbox
);
  localparam int CNT_W = $clog2(MIN_PIXELS + 1);

  logic [1:0]         state;
  bbox_t              acc, acc_base, acc_nxt;
  logic [CNT_W-1:0]   cnt, cnt_base, cnt_nxt;
  logic [COORD_W-1:0] x, y;
  logic               last, accept, restart, hit;

  assign restart = pixel_valid && sof;
  assign accept  = pixel_valid && (sof || state == ST_SCAN);
  assign hit     = accept && (pixel_in >= threshold);

  hand_bbox_tracker_raster_counter #(.H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE)) u_raster (
    .clk  (clk),
    .reset(reset),
    .step (accept),
    .sof  (sof),
    .x    (x),
    .y    (y),
    .last (last)
  );

  // FINALIZE always clears; the commit reads the pre-clear values on the same edge.
  always_comb begin
    acc_base = acc;
    cnt_base = cnt;
    if (restart || state == ST_FINAL) begin
      acc_base = BBOX_INIT;
      cnt_base = '0;
    end
    acc_nxt = acc_base;
    cnt_nxt = cnt_base;
    if (hit) begin
      if (x < acc_base.x_min) acc_nxt.x_min = x;
      if (x > acc_base.x_max) acc_nxt.x_max = x;
      if (y < acc_base.y_min) acc_nxt.y_min = y;
      if (y > acc_base.y_max) acc_nxt.y_max = y;
      if (cnt_base < CNT_W'(MIN_PIXELS)) cnt_nxt = cnt_base + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= ST_IDLE;
      acc                <= BBOX_INIT;
      cnt                <= '0;
      bbox.hand_x_min    <= '0;
      bbox.hand_x_max    <= '0;
      bbox.hand_y_min    <= '0;
      bbox.hand_y_max    <= '0;
      bbox.bbox_found    <= 1'b0;
      bbox.bbox_valid    <= 1'b0;
      bbox.frame_dropped <= 1'b0;
    end else begin
      acc                <= acc_nxt;
      cnt                <= cnt_nxt;
      bbox.bbox_valid    <= (state == ST_FINAL);
      bbox.frame_dropped <= restart && (state == ST_SCAN);

      if (accept && last)    state <= ST_FINAL;
      else if (restart)      state <= ST_SCAN;
      else if (state == ST_FINAL) state <= ST_IDLE;

      if (state == ST_FINAL) begin
        bbox.bbox_found <= (cnt >= CNT_W'(MIN_PIXELS));
        if (cnt >= CNT_W'(MIN_PIXELS)) begin
          bbox.hand_x_min <= acc.x_min;
          bbox.hand_x_max <= acc.x_max;
          bbox.hand_y_min <= acc.y_min;
          bbox.hand_y_max <= acc.y_max;
        end
      end
    end
  end
endmodule

// File: tb/tb_hand_bbox_tracker.sv
// Directed bench for hand_bbox_tracker on a 16x8 raster with MIN_PIXELS=4.
module tb_hand_bbox_tracker;
  import hand_bbox_tracker_pkg::*;
  localparam int H = 16, V = 8, MINP = 4;
  typedef logic [4*COORD_W-1:0] box_t;

  logic       clk = 1'b0, reset = 1'b1;
  logic [7:0] pixel_in = '0, threshold = 8'd128;
  logic       pixel_valid = 1'b0, sof = 1'b0;

  hand_bbox_tracker_if b();
  hand_bbox_tracker #(.H_ACTIVE(H), .V_ACTIVE(V), .MIN_PIXELS(MINP)) dut (
    .clk(clk), .reset(reset), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
    .sof(sof), .threshold(threshold), .bbox(b)
  );

  always #5 clk = ~clk;

  int   errors = 0, checks = 0, valid_cnt = 0, drop_cnt = 0;
  box_t caps[$];
  logic fcaps[$];
  box_t cur_box;
  assign cur_box = {b.hand_x_min, b.hand_x_max, b.hand_y_min, b.hand_y_max};

  function automatic box_t mkbox(int x0, int x1, int y0, int y1);
    return {COORD_W'(x0), COORD_W'(x1), COORD_W'(y0), COORD_W'(y1)};
  endfunction

  function automatic logic [7:0] pixval(int mode, int x, int y);
    case (mode)
      0: return (x >= 3 && x <= 6 && y >= 2 && y <= 4) ? 8'd200 : 8'd10;
      1: return (y == 0 && x < 3) ? 8'd200 : 8'd10;
      2: return ((x == 0 && y == 0) || (x == 15 && y == 7) || (y == 3 && (x == 8 || x == 9)))
                ? 8'd128 : 8'd127;
      default: return (x >= 5 && x <= 10 && y >= 1 && y <= 6) ? 8'd200 : 8'd10;
    endcase
  endfunction

  // Pulse monitor on the sampling edge; checks read these counters only after #1.
  always @(negedge clk) begin
    if (!reset) begin
      if (b.bbox_valid) begin
        valid_cnt++;
        caps.push_back(cur_box);
        fcaps.push_back(b.bbox_found);
      end
      if (b.frame_dropped) drop_cnt++;
    end
  end

  task automatic pix(input logic [7:0] v, input logic s);
    @(negedge clk);
    pixel_in = v; sof = s; pixel_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      pixel_valid = 1'b0; sof = 1'b0;
    end
    #1;
  endtask

  // Gap cycles carry sof=1 and junk data with pixel_valid low; they must be ignored.
  task automatic frame(input int mode, input bit gaps, input int npix);
    for (int i = 0; i < npix; i++) begin
      if (gaps && $urandom_range(0, 2) == 0)
        repeat ($urandom_range(1, 3)) begin
          @(negedge clk);
          pixel_valid = 1'b0; sof = 1'b1; pixel_in = 8'hFF;
        end
      pix(pixval(mode, i % H, i / H), i == 0);
    end
  endtask

  task automatic test_reset();
    idle(2);
    checks++; if (cur_box !== '0) begin errors++; $display("FAIL reset_box got=%h exp=0", cur_box); end
    checks++; if ({b.bbox_found, b.bbox_valid, b.frame_dropped} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got=%b exp=000", {b.bbox_found, b.bbox_valid, b.frame_dropped}); end
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 20; i++) pix(8'd200, 1'b0);
    idle(4);
    checks++; if (valid_cnt !== 0 || drop_cnt !== 0) begin
      errors++; $display("FAIL idle_no_pulse got valid=%0d drop=%0d exp 0 0", valid_cnt, drop_cnt); end
    checks++; if (cur_box !== '0 || b.bbox_found !== 1'b0) begin
      errors++; $display("FAIL idle_outputs got=%h found=%b exp=0 0", cur_box, b.bbox_found); end
  endtask

  task automatic test_rectangle();
    frame(0, 1'b0, H*V);
    @(negedge clk); pixel_valid = 1'b0; sof = 1'b0;
    checks++; if (b.bbox_valid !== 1'b0) begin errors++; $display("FAIL rect_early_valid got=%b exp=0", b.bbox_valid); end
    @(negedge clk);
    checks++; if (b.bbox_valid !== 1'b1) begin errors++; $display("FAIL rect_latency got=%b exp=1", b.bbox_valid); end
    checks++; if (cur_box !== mkbox(3, 6, 2, 4)) begin
      errors++; $display("FAIL rect_box got=%h exp=%h", cur_box, mkbox(3, 6, 2, 4)); end
    checks++; if (b.bbox_found !== 1'b1) begin errors++; $display("FAIL rect_found got=%b exp=1", b.bbox_found); end
    @(negedge clk);
    checks++; if (b.bbox_valid !== 1'b0) begin errors++; $display("FAIL rect_pulse_width got=%b exp=0", b.bbox_valid); end
    idle(2);
    checks++; if (valid_cnt !== 1) begin errors++; $display("FAIL rect_count got=%0d exp=1", valid_cnt); end
  endtask

  task automatic test_too_few();
    int v0 = valid_cnt;
    frame(1, 1'b0, H*V);
    idle(4);
    checks++; if (valid_cnt !== v0 + 1) begin errors++; $display("FAIL few_pulse got=%0d exp=%0d", valid_cnt, v0 + 1); end
    checks++; if (b.bbox_found !== 1'b0) begin errors++; $display("FAIL few_found got=%b exp=0", b.bbox_found); end
    checks++; if (cur_box !== mkbox(3, 6, 2, 4)) begin
      errors++; $display("FAIL few_hold got=%h exp=%h", cur_box, mkbox(3, 6, 2, 4)); end
  endtask

  task automatic test_threshold_edges();
    frame(2, 1'b0, H*V);
    idle(4);
    checks++; if (cur_box !== mkbox(0, 15, 0, 7)) begin
      errors++; $display("FAIL edge_box got=%h exp=%h", cur_box, mkbox(0, 15, 0, 7)); end
    checks++; if (b.bbox_found !== 1'b1) begin errors++; $display("FAIL edge_found got=%b exp=1", b.bbox_found); end
  endtask

  task automatic test_early_sof_gaps();
    int v0 = valid_cnt, d0 = drop_cnt;
    frame(0, 1'b0, 40);
    frame(3, 1'b1, H*V);
    idle(4);
    checks++; if (drop_cnt !== d0 + 1) begin errors++; $display("FAIL drop_pulse got=%0d exp=%0d", drop_cnt, d0 + 1); end
    checks++; if (valid_cnt !== v0 + 1) begin errors++; $display("FAIL drop_commits got=%0d exp=%0d", valid_cnt, v0 + 1); end
    checks++; if (cur_box !== mkbox(5, 10, 1, 6) || b.bbox_found !== 1'b1) begin
      errors++; $display("FAIL gap_box got=%h found=%b exp=%h 1", cur_box, b.bbox_found, mkbox(5, 10, 1, 6)); end
  endtask

  task automatic test_back_to_back();
    int v0 = valid_cnt, d0 = drop_cnt;
    frame(0, 1'b0, H*V);
    frame(2, 1'b0, H*V);
    idle(4);
    checks++; if (valid_cnt !== v0 + 2 || drop_cnt !== d0) begin
      errors++; $display("FAIL b2b_pulses got valid=%0d drop=%0d exp %0d %0d", valid_cnt, drop_cnt, v0 + 2, d0); end
    checks++; if (caps[caps.size()-2] !== mkbox(3, 6, 2, 4) || fcaps[fcaps.size()-2] !== 1'b1) begin
      errors++; $display("FAIL b2b_first got=%h exp=%h", caps[caps.size()-2], mkbox(3, 6, 2, 4)); end
    checks++; if (caps[caps.size()-1] !== mkbox(0, 15, 0, 7) || fcaps[fcaps.size()-1] !== 1'b1) begin
      errors++; $display("FAIL b2b_second got=%h exp=%h", caps[caps.size()-1], mkbox(0, 15, 0, 7)); end
  endtask

  task automatic test_reset_mid();
    int v0 = valid_cnt, d0 = drop_cnt;
    frame(3, 1'b0, 50);
    @(negedge clk); reset = 1'b1; pixel_valid = 1'b0; sof = 1'b0;
    @(negedge clk); #1;
    checks++; if (cur_box !== '0 || b.bbox_found !== 1'b0) begin
      errors++; $display("FAIL midrst_outputs got=%h found=%b exp=0 0", cur_box, b.bbox_found); end
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 30; i++) pix(8'd200, 1'b0);
    idle(6);
    checks++; if (valid_cnt !== v0 || drop_cnt !== d0) begin
      errors++; $display("FAIL midrst_pulses got valid=%0d drop=%0d exp %0d %0d", valid_cnt, drop_cnt, v0, d0); end
    frame(0, 1'b0, H*V);
    idle(4);
    checks++; if (cur_box !== mkbox(3, 6, 2, 4) || b.bbox_found !== 1'b1 || valid_cnt !== v0 + 1) begin
      errors++; $display("FAIL midrst_recover got=%h found=%b commits=%0d exp=%h 1 %0d",
                         cur_box, b.bbox_found, valid_cnt, mkbox(3, 6, 2, 4), v0 + 1); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_rectangle();
    test_too_few();
    test_threshold_edges();
    test_early_sof_gaps();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hand_bbox_tracker.md
Name: hand_bbox_tracker

Overview:
- Scans the incoming 8-bit pixel stream and finds pixels whose value is at or above a runtime threshold ("hand" pixels).
- Accumulates the min/max X/Y of those pixels over one frame.
- At end of frame, publishes the box as hand_x_min/hand_x_max/hand_y_min/hand_y_max.
- These outputs are the producer side of the bounding-box interface consumed by the border-overlay stage downstream.

Parameters:
- H_ACTIVE, 640: active pixels per line.
- V_ACTIVE, 480: active lines per frame.
- MIN_PIXELS, 64: minimum hand-pixel count for a box to be reported as found.
- COORD_W, 11: coordinate width; fixed by the overlay interface.

Ports:
- clk  input  1  system clock; single clock domain.
- reset  input  1  synchronous, active-high reset.
- pixel_in  input  8  pixel value (grayscale/colour channel).
- pixel_valid  input  1  pixel_in valid this cycle; pixel accepted when high.
- sof  input  1  start of frame; qualifies the accepted pixel as (0,0); ignored when pixel_valid=0.
- threshold  input  8  hand-pixel threshold (hit = pixel_in >= threshold); sampled per pixel.
- hand_x_min  output  COORD_W  committed box left edge.
- hand_x_max  output  COORD_W  committed box right edge.
- hand_y_min  output  COORD_W  committed box top edge.
- hand_y_max  output  COORD_W  committed box bottom edge.
- bbox_found  output  1  level; last committed frame had >= MIN_PIXELS hits.
- bbox_valid  output  1  one-cycle pulse when a frame commit completes.
- frame_dropped  output  1  one-cycle pulse when a frame is aborted by an early sof.

Behaviour:
- Reset values (synchronous reset, active-high):
  - All hand_* outputs = 0; bbox_found = 0; bbox_valid = 0; frame_dropped = 0.
  - State = IDLE; x/y counters = 0; hit count = 0.
  - Accumulators: min registers = all-ones; max registers = 0.
- States:
  - IDLE: waits for an accepted pixel with sof=1, which becomes (0,0) → SCAN. Pixels without sof are ignored.
  - SCAN: every accepted pixel advances x; at x = H_ACTIVE-1, x wraps to 0 and y increments.
    - The accepted pixel at (H_ACTIVE-1, V_ACTIVE-1) is the last pixel of the frame → FINALIZE.
  - FINALIZE: lasts exactly one cycle, then → IDLE (or SCAN, see boundaries).
- Hit update (same edge the pixel is accepted):
  - min_x = min(min_x, x); max_x = max(max_x, x); same for y.
  - hit count increments, saturating at MIN_PIXELS.
- Commit (end of FINALIZE):
  - If hit count >= MIN_PIXELS: hand_* <= accumulators and bbox_found <= 1.
  - Otherwise: hand_* hold their previous values and bbox_found <= 0.
  - bbox_valid = 1 for exactly the following cycle.
  - Accumulators and count are re-initialised.
- Latency: last pixel accepted in cycle N → new hand_* values visible and bbox_valid high in cycle N+2.
- hand_* change only at commit; they are stable for the whole frame.
- Boundary conditions:
  - sof with pixel_valid during SCAN (early sof): abort the frame, no commit, frame_dropped pulses the next cycle. That pixel is taken as (0,0) of a new frame; accumulators and count restart from that pixel alone.
  - sof with pixel_valid during FINALIZE: commit proceeds normally; the pixel is also accepted as (0,0) of the new frame → SCAN.
  - Non-sof pixel during FINALIZE or IDLE: ignored.
  - pixel_valid low: counters and accumulators hold; gaps of any length are allowed inside a frame.
  - Hit at the last pixel of the frame is included in the commit.
  - Single-pixel box: min == max is legal.
  - Reset mid-frame: everything returns to reset values; the partial frame is discarded, no pulses.
  - x/y never exceed H_ACTIVE-1 / V_ACTIVE-1.

Decomposition:
- Shared package (vision_pkg): COORD_W, default H_ACTIVE/V_ACTIVE, tracker state enumeration (IDLE, SCAN, FINALIZE), accumulator reset constants (min = {COORD_W{1'b1}}, max = 0).
- One natural sub-module, raster_counter: x/y counters with sof resync and last-pixel flag. The tracker FSM and accumulators stay in hand_bbox_tracker.

Test Plan:
- Bench parameters: H_ACTIVE=16, V_ACTIVE=8, MIN_PIXELS=4, threshold=128.
- Reset: assert reset 2 cycles → all outputs 0, no pulses; pixels without sof in IDLE produce no activity.
- Rectangle: 200 at x 3..6, y 2..4, else 10, contiguous pixel_valid → bbox_valid 2 cycles after last pixel; box (3,6,2,4); bbox_found=1.
- Too few hits: next frame has 3 hits → bbox_valid pulses; bbox_found=0; hand_* hold (3,6,2,4).
- Threshold and edges: pixel 128 at (0,0) and (15,7), 127 elsewhere, plus 2 more 128 pixels at (8,3),(9,3) → box (0,15,0,7); found=1.
- Early sof / gaps: sof at frame pixel 40 → frame_dropped pulse, no bbox_valid; the following frame with random pixel_valid gaps commits correctly.
- Back-to-back and reset: sof in the FINALIZE cycle → commit and new frame both correct. Reset mid-SCAN → outputs return to 0 and no bbox_valid for the partial frame.
